uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, the pclk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, the serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, the receive FIFO entries; power of two, at least 2.
REQ-004 SHALL have port pclk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high (wired to the SoC TXD pin).
REQ-007 SHALL have port rx_data, output, 8 bits: FIFO head byte.
REQ-008 SHALL have port rx_valid, output, 1 bit: FIFO not empty.
REQ-009 SHALL have port rx_ready, input, 1 bit: consumer pop; a pop occurs when rx_valid and rx_ready are both high.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag set when a byte is dropped.
REQ-012 SHALL have port clr_overrun, input, 1 bit: synchronous clear of overrun.
REQ-013 SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.

Function
REQ-014 SHALL set CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division), with HALF = CLKS_PER_BIT / 2.
REQ-015 SHALL pass rxd through a 2-flop synchronizer; all decoding uses the synchronized value rxs.
REQ-016 SHALL implement the states IDLE, START, DATA and STOP.
REQ-017 SHALL move from IDLE to START on a falling edge of rxs (previous 1, current 0), clearing the bit counter.
REQ-018 SHALL, in START after HALF cycles, go to DATA if rxs=0; if rxs=1 it is a false start and SHALL return to IDLE with no flag.
REQ-019 SHALL, in DATA, sample rxs every CLKS_PER_BIT cycles for 8 bits, LSB first, then go to STOP.
REQ-020 SHALL, in STOP after CLKS_PER_BIT cycles: if rxs=1, push the byte; if rxs=0, drop it, pulse frame_err and not push.
REQ-021 SHALL go to IDLE after STOP; a following start is accepted only after rxs has been high, so a break (line stuck low) yields exactly one frame_err.
REQ-022 SHALL make a pushed byte visible on rx_valid/rx_data on the cycle after the stop-bit sample.
REQ-023 SHALL pop on rx_valid and rx_ready, with the next entry visible on the following cycle.
REQ-024 SHALL, when full with no pop in the same cycle, discard the incoming byte, set overrun and leave the FIFO contents unchanged.
REQ-025 SHALL, when full with a pop in the same cycle, accept the push with no overrun; level stays FIFO_DEPTH.
REQ-026 SHALL, on a simultaneous push and pop when non-empty, perform both; level is unchanged.
REQ-027 SHALL give clr_overrun priority below a same-cycle overrun set, so overrun stays 1.
REQ-028 SHALL wrap the FIFO pointers modulo FIFO_DEPTH; level never exceeds FIFO_DEPTH.

Reset
REQ-029 SHALL, while resetn=0, set state=IDLE, synchronizer flops=1, counters=0, pointers=0, level=0, rx_valid=0, frame_err=0, overrun=0, rx_data=0.
REQ-030 SHALL, on reset mid-frame, discard the partial frame; after release a new start needs a fresh falling edge.

Structure
REQ-031 SHALL place the state encoding and a function computing CLKS_PER_BIT in shared package uart_pkg, also used by a future uart_tx.
REQ-032 SHALL implement the FIFO as sub-module uart_sync_fifo (parameter DEPTH, width 8, ports push/pop/full/empty/level); the receive FSM stays in uart_rx_fifo.

Verification
All scenarios use CLK_FREQ_HZ=1600000, BAUD_RATE=100000 (16 clocks per bit) and FIFO_DEPTH=8.
REQ-033 SHALL cover reset: hold resetn=0 with rxd=1, release -> rx_valid=0, level=0, overrun=0, frame_err never pulses.
REQ-034 SHALL cover a single byte: send 0x55 in 8N1 -> rx_valid rises within 160+4 cycles of the start edge with rx_data=0x55; a pop with rx_ready=1 -> level=0.
REQ-035 SHALL cover a glitch: drive rxd low for 4 cycles -> no push and no frame_err; then send 0xA3 -> 0xA3 is received.
REQ-036 SHALL cover a framing error: send 0x3C with stop bit 0 -> one frame_err pulse, level stays 0; a following 0x81 -> received correctly.
REQ-037 SHALL cover overflow: with rx_ready=0, send 0x00..0x08 -> level=8, overrun=1, pops return 0x00..0x07 in order; pulse clr_overrun -> overrun=0.
REQ-038 SHALL cover reset mid-frame: assert resetn=0 during the DATA bits of 0xFF, release, send 0x12 -> only 0x12 is received, no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver here and for a future transmitter.
//   uart_state_t : frame-decoder states (idle, start bit, data bits, stop bit)
//   DATA_BITS    : bits per character (8N1 framing)
//   clks_per_bit : clock cycles per serial bit, truncated toward zero
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with first-word-fall-through output.
// Ports:
//   pclk, resetn : clock, asynchronous active-low reset
//   push, din    : write request and data (ignored when full unless popping)
//   pop          : read request (ignored when empty)
//   dout         : head entry, valid while empty is low
//   full, empty  : occupancy flags
//   level        : number of stored entries, 0..DEPTH
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                 pclk,
    input  logic                 resetn,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty,
    output logic [LW-1:0]        level
);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [LW-1:0]        level_reg;
    logic                 push_ok;
    logic                 pop_ok;

    assign full  = (level_reg == LW'(DEPTH));
    assign empty = (level_reg == '0);
    assign level = level_reg;
    assign dout  = mem[rd_ptr_reg];

    // A write into a full FIFO is legal only if the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Entries are resettable so the head reads zero straight out of reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge pclk or negedge resetn) begin
                if (!resetn) begin
                    mem[gi] <= '0;
                end else if (push_ok && (wr_ptr_reg == AW'(gi))) begin
                    mem[gi] <= din;
                end
            end
        end
    endgenerate

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH naturally.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO.
// Ports:
//   pclk, resetn : clock, asynchronous active-low reset
//   rxd          : asynchronous serial input, idle high
//   rx_data      : FIFO head byte
//   rx_valid     : FIFO not empty
//   rx_ready     : consumer pop (effective when rx_valid is also high)
//   frame_err    : one-cycle pulse when a stop bit samples low
//   overrun      : sticky, set when a received byte is dropped on a full FIFO
//   clr_overrun  : synchronous clear of overrun (a same-cycle set wins)
//   level        : FIFO occupancy
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 8,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 pclk,
    input  logic                 resetn,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 clr_overrun,
    output logic [LW-1:0]        level
);

    localparam int CPB  = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);

    logic                 sync1_reg;
    logic                 rxs_reg;
    logic                 rxs_prev_reg;
    uart_state_t          state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [2:0]           bit_reg, bit_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 overrun_reg, overrun_next;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;

    // Two-flop synchronizer plus one more flop for falling-edge detection.
    // All three reset high so a line held low through reset is not a start.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            sync1_reg    <= 1'b1;
            rxs_reg      <= 1'b1;
            rxs_prev_reg <= 1'b1;
        end else begin
            sync1_reg    <= rxd;
            rxs_reg      <= sync1_reg;
            rxs_prev_reg <= rxs_reg;
        end
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_reg       <= '0;
            shift_reg     <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_reg       <= bit_next;
            shift_reg     <= shift_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + 1'b1;
        bit_next       = bit_reg;
        shift_next     = shift_reg;
        frame_err_next = 1'b0;
        push           = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                // Requires a real 1->0 transition, so a line stuck low after
                // a bad stop bit cannot retrigger reception.
                if (rxs_prev_reg && !rxs_reg) begin
                    state_next = START;
                    bit_next   = '0;
                end
            end
            START: begin
                if (cnt_reg == CW'(HALF - 1)) begin
                    cnt_next   = '0;
                    state_next = rxs_reg ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_reg == CW'(CPB - 1)) begin
                    cnt_next   = '0;
                    shift_next = {rxs_reg, shift_reg[DATA_BITS-1:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt_reg == CW'(CPB - 1)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rxs_reg) push = 1'b1;
                    else         frame_err_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pop = rx_ready && !empty;

    always_comb begin
        overrun_next = overrun_reg;
        if (push && full && !pop) overrun_next = 1'b1;
        else if (clr_overrun)     overrun_next = 1'b0;
    end

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .pclk   (pclk),
        .resetn (resetn),
        .push   (push),
        .din    (shift_reg),
        .pop    (pop),
        .dout   (rx_data),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    assign rx_valid  = !empty;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule
